vpu_lane_seq: RTL and testbench

VPU_LANE_SEQ -- requirements
Module: vpu_lane_seq

---
 rtl/vpu_lane_seq.sv | 166 ++++++++++++++++
 tb/tb_vpu_lane_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_lane_seq.sv
// vpu_lane_seq: vector-lane sequencer for a scalar FALU.
//   Takes an 8-lane x 16-bit vector op and feeds it to the FALU one lane per
//   cycle. It collects each lane result into vd, gt_mask and eq_mask, then
//   holds the packed result until the consumer takes it.
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   issue_*                  op request (opsel one-hot, vl, vs1, vs2, fs1)
//   falu_*                   per-lane drive to the FALU and its result inputs
//   res_valid/res_ready      result handshake; vd, gt_mask, eq_mask payload
//   flush                    drops whatever is in flight and blocks issue
// Build option: define VPU_MASK_EN to add the per-lane vmask input.
module vpu_lane_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         issue_valid,
  output logic         issue_ready,
  input  logic [7:0]   opsel,
  input  logic [3:0]   vl,
  input  logic [127:0] vs1,
  input  logic [127:0] vs2,
  input  logic [31:0]  fs1,
`ifdef VPU_MASK_EN
  input  logic [7:0]   vmask,
`endif
  output logic         falu_enable,
  output logic [15:0]  falu_op1,
  output logic [15:0]  falu_op2,
  output logic [7:0]   falu_sel,
  output logic [31:0]  falu_fullin,
  output logic         falu_vec_en,
  input  logic [15:0]  falu_opout,
  input  logic         falu_gt,
  input  logic         falu_eq,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] vd,
  output logic [7:0]   gt_mask,
  output logic [7:0]   eq_mask,
  input  logic         flush
);

  localparam int NUM_LANES = 8;
  localparam int VEC_W     = 16;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                              state_q, state_d;
  logic [2:0]                          cnt_q, cnt_d;
  logic [3:0]                          len_q, len_d;
  logic [7:0]                          op_q, op_d;
  logic [NUM_LANES-1:0]                lmask_q, lmask_d;
  logic [31:0]                         fs1_q, fs1_d;
  logic [NUM_LANES-1:0][VEC_W-1:0]     vs1_q, vs1_d, vs2_q, vs2_d, vd_q, vd_d;
  logic [NUM_LANES-1:0]                gt_q, gt_d, eq_q, eq_d;

  logic op_onehot, lane_act, last_lane, accept;

  // Non-one-hot selects and masked-off lanes are never sent to the FALU.
  // Their vd lane keeps the vs1 value that was preloaded at issue.
  assign op_onehot = (op_q != 8'd0) && ((op_q & (op_q - 8'd1)) == 8'd0);
  assign lane_act  = op_onehot && lmask_q[cnt_q];
  assign last_lane = ({1'b0, cnt_q} == (len_q - 4'd1));
  assign accept    = issue_valid && issue_ready;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      op_q    <= '0;
      lmask_q <= '0;
      fs1_q   <= '0;
      vs1_q   <= '0;
      vs2_q   <= '0;
      vd_q    <= '0;
      gt_q    <= '0;
      eq_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      op_q    <= op_d;
      lmask_q <= lmask_d;
      fs1_q   <= fs1_d;
      vs1_q   <= vs1_d;
      vs2_q   <= vs2_d;
      vd_q    <= vd_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
    end
  end

  // Next state: flush overrides every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)    state_d = S_RUN;
      S_RUN:   if (last_lane) state_d = S_DONE;
      S_DONE:  if (res_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Datapath next values
  always_comb begin
    cnt_d   = cnt_q;
    len_d   = len_q;
    op_d    = op_q;
    lmask_d = lmask_q;
    fs1_d   = fs1_q;
    vs1_d   = vs1_q;
    vs2_d   = vs2_q;
    vd_d    = vd_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    if (accept) begin
      op_d  = opsel;
      fs1_d = fs1;
      vs1_d = vs1;
      vs2_d = vs2;
      len_d = (vl == 4'd0 || vl > 4'd8) ? 4'd8 : vl;
`ifdef VPU_MASK_EN
      lmask_d = vmask;
`else
      lmask_d = '1;
`endif
      cnt_d = '0;
      // Preload vs1 so tail, masked and disabled lanes need no extra write.
      vd_d  = vs1;
      gt_d  = '0;
      eq_d  = '0;
    end else if (state_q == S_RUN && !flush) begin
      if (lane_act) begin
        vd_d[cnt_q] = falu_opout;
        gt_d[cnt_q] = falu_gt;
        eq_d[cnt_q] = falu_eq;
      end
      cnt_d = cnt_q + 3'd1;
    end
  end

  // Outputs
  always_comb begin
    issue_ready = (state_q == S_IDLE) && !flush;
    res_valid   = (state_q == S_DONE) && !flush;
    falu_enable = 1'b0;
    falu_sel    = '0;
    falu_op1    = '0;
    falu_op2    = '0;
    falu_fullin = '0;
    falu_vec_en = 1'b0;
    if (state_q == S_RUN) begin
      falu_op1    = vs1_q[cnt_q];
      falu_op2    = vs2_q[cnt_q];
      falu_fullin = fs1_q;
      falu_enable = lane_act;
      falu_sel    = lane_act ? op_q : 8'd0;
    end
    vd      = vd_q;
    gt_mask = gt_q;
    eq_mask = eq_q;
  end

endmodule

// File: tb/tb_vpu_lane_seq.sv
module tb_vpu_lane_seq;
  logic         clk = 1'b0;
  logic         rst;
  logic         issue_valid, issue_ready;
  logic [7:0]   opsel;
  logic [3:0]   vl;
  logic [127:0] vs1, vs2;
  logic [31:0]  fs1;
`ifdef VPU_MASK_EN
  logic [7:0]   vmask;
`endif
  logic         falu_enable, falu_vec_en, falu_gt, falu_eq;
  logic [15:0]  falu_op1, falu_op2, falu_opout;
  logic [7:0]   falu_sel;
  logic [31:0]  falu_fullin;
  logic         res_valid, res_ready, flush;
  logic [127:0] vd;
  logic [7:0]   gt_mask, eq_mask;

  vpu_lane_seq dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .opsel(opsel), .vl(vl), .vs1(vs1), .vs2(vs2), .fs1(fs1),
`ifdef VPU_MASK_EN
    .vmask(vmask),
`endif
    .falu_enable(falu_enable), .falu_op1(falu_op1), .falu_op2(falu_op2),
    .falu_sel(falu_sel), .falu_fullin(falu_fullin), .falu_vec_en(falu_vec_en),
    .falu_opout(falu_opout), .falu_gt(falu_gt), .falu_eq(falu_eq),
    .res_valid(res_valid), .res_ready(res_ready),
    .vd(vd), .gt_mask(gt_mask), .eq_mask(eq_mask), .flush(flush)
  );

  always #5 clk = ~clk;

  // FALU stub: 1.0 + 2.0 -> 3.0, otherwise an unsigned 16-bit sum.
  // The flags compare the two operands as unsigned values.
  assign falu_opout = (falu_op1 == 16'h3C00 && falu_op2 == 16'h4000) ? 16'h4200
                                                                      : falu_op1 + falu_op2;
  assign falu_gt = falu_op1 > falu_op2;
  assign falu_eq = falu_op1 == falu_op2;

  int n_chk = 0, n_pass = 0;
  int en_cnt = 0;
  logic [7:0]  last_sel;
  logic [31:0] last_full;

  always @(negedge clk) begin
    if (falu_enable) begin
      en_cnt++;
      last_sel  = falu_sel;
      last_full = falu_fullin;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Issues one op, then returns at the negedge where res_valid is first seen.
  // lat counts cycles with the accept cycle as 0; -1 means the wait timed out.
  task automatic run_op(input logic [7:0] op, input logic [3:0] l, input logic [127:0] a,
                        input logic [127:0] b, input logic [31:0] f, input logic [7:0] vm,
                        output int lat);
    @(negedge clk);
    en_cnt = 0;
    opsel = op; vl = l; vs1 = a; vs2 = b; fs1 = f;
`ifdef VPU_MASK_EN
    vmask = vm;
`else
    if (vm != 8'hFF) $display("note: vmask ignored in this build");
`endif
    issue_valid = 1'b1;
    @(posedge clk);
    #1 issue_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (res_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  // Completes the result handshake from the current negedge.
  task automatic finish_op(input string nm);
    res_ready = 1'b1;
    #1 chk({nm, " issue_ready in exit cycle"}, issue_ready, 1'b0);
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    chk({nm, " idle after handshake"}, {res_valid, issue_ready}, 2'b01);
    chk({nm, " falu idle outputs"},
        {falu_enable, falu_sel, falu_op1, falu_op2, falu_fullin, falu_vec_en}, '0);
  endtask

  typedef struct {
    logic [7:0]   op;
    logic [3:0]   vl;
    logic [127:0] vs1, vs2;
    logic [31:0]  fs1;
    logic [127:0] vd;
    logic [7:0]   gt, eq;
    int           lat, en;
  } vec_t;

  vec_t tbl[7];
  int   lat, bad;
  logic [127:0] snap;

  initial begin
    tbl[0] = '{8'h01, 4'd4, {8{16'h3C00}}, {8{16'h4000}}, 32'h0,
               128'h3C00_3C00_3C00_3C00_4200_4200_4200_4200, 8'h00, 8'h00, 5, 4};
    tbl[1] = '{8'h20, 4'd0, 128'h0007_0006_0005_0004_0003_0002_0001_0000, 128'h0, 32'h0,
               128'h0007_0006_0005_0004_0003_0002_0001_0000, 8'hFE, 8'h01, 9, 8};
    tbl[2] = '{8'h03, 4'd2, 128'h1111_2222_3333_4444_5555_6666_7777_8888, {8{16'h0001}}, 32'h0,
               128'h1111_2222_3333_4444_5555_6666_7777_8888, 8'h00, 8'h00, 3, 0};
    tbl[3] = '{8'h02, 4'd9, {8{16'h0005}}, {4{16'h0003, 16'h0005}}, 32'h0,
               {4{16'h0008, 16'h000A}}, 8'hAA, 8'h55, 9, 8};
    tbl[4] = '{8'h80, 4'd1, {{7{16'hAAAA}}, 16'h1234}, {{7{16'h0000}}, 16'h0001}, 32'h3F80_0000,
               {{7{16'hAAAA}}, 16'h1235}, 8'h01, 8'h00, 2, 1};
    tbl[5] = '{8'h00, 4'd8, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 128'h0, 32'h0,
               128'h1111_2222_3333_4444_5555_6666_7777_8888, 8'h00, 8'h00, 9, 0};
    tbl[6] = '{8'h10, 4'd15, {8{16'h0100}}, {8{16'h0100}}, 32'h0,
               {8{16'h0200}}, 8'h00, 8'hFF, 9, 8};

    rst = 1'b1; issue_valid = 1'b0; res_ready = 1'b0; flush = 1'b0;
    opsel = '0; vl = '0; vs1 = '0; vs2 = '0; fs1 = '0;
`ifdef VPU_MASK_EN
    vmask = 8'hFF;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset ready/valid", {issue_ready, res_valid}, 2'b10);
    chk("reset vd/masks", {vd, gt_mask, eq_mask}, '0);
    chk("reset falu outputs", {falu_enable, falu_sel, falu_op1, falu_op2, falu_fullin}, '0);

    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].op, tbl[i].vl, tbl[i].vs1, tbl[i].vs2, tbl[i].fs1, 8'hFF, lat);
      chk($sformatf("v%0d latency", i), lat, tbl[i].lat);
      chk($sformatf("v%0d vd", i), vd, tbl[i].vd);
      chk($sformatf("v%0d gt_mask", i), gt_mask, tbl[i].gt);
      chk($sformatf("v%0d eq_mask", i), eq_mask, tbl[i].eq);
      chk($sformatf("v%0d falu enables", i), en_cnt, tbl[i].en);
      if (i == 4) chk("ftl sel/fullin", {last_sel, last_full}, {8'h80, 32'h3F80_0000});
      finish_op($sformatf("v%0d", i));
    end

    // Flush in lane 2 together with a new issue request
    @(negedge clk);
    opsel = 8'h01; vl = 4'd8; vs1 = tbl[0].vs1; vs2 = tbl[0].vs2; issue_valid = 1'b1;
    @(posedge clk);
    #1 issue_valid = 1'b0;
    repeat (3) @(negedge clk);
    flush = 1'b1; issue_valid = 1'b1;
    #1 chk("flush blocks issue", issue_ready, 1'b0);
    @(posedge clk);
    #1 flush = 1'b0; issue_valid = 1'b0;
    @(negedge clk);
    chk("flush -> idle", {issue_ready, res_valid}, 2'b10);
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (res_valid) bad++;
    end
    chk("flush drops result", bad, 0);
    run_op(tbl[0].op, tbl[0].vl, tbl[0].vs1, tbl[0].vs2, tbl[0].fs1, 8'hFF, lat);
    chk("post-flush latency", lat, 5);
    chk("post-flush vd", vd, tbl[0].vd);
    finish_op("post-flush");

    // Back-pressure: result held for 10 cycles
    run_op(tbl[3].op, tbl[3].vl, tbl[3].vs1, tbl[3].vs2, tbl[3].fs1, 8'hFF, lat);
    chk("stall latency", lat, 9);
    snap = vd;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!res_valid || issue_ready || vd !== snap || gt_mask !== 8'hAA || eq_mask !== 8'h55) bad++;
    end
    chk("stall stable", bad, 0);
    chk("stall vd", vd, tbl[3].vd);
    finish_op("stall");

    // Flush while the result is waiting
    run_op(tbl[4].op, tbl[4].vl, tbl[4].vs1, tbl[4].vs2, tbl[4].fs1, 8'hFF, lat);
    flush = 1'b1;
    #1 chk("flush in done hides valid", res_valid, 1'b0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush in done -> idle", {issue_ready, res_valid}, 2'b10);

    // Reset in the middle of RUN
    @(negedge clk);
    opsel = 8'h20; vl = 4'd0; vs1 = tbl[1].vs1; vs2 = '0; issue_valid = 1'b1;
    @(posedge clk);
    #1 issue_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (res_valid) bad++;
    end
    chk("rst mid-run no valid", bad, 0);
    chk("rst mid-run state", {issue_ready, vd, gt_mask, eq_mask}, {1'b1, 144'h0});

`ifdef VPU_MASK_EN
    run_op(8'h04, 4'd4, 128'h0080_0070_0060_0050_0040_0030_0020_0010, {8{16'h0010}},
           32'h0, 8'h05, lat);
    chk("mask latency", lat, 5);
    chk("mask vd", vd, 128'h0080_0070_0060_0050_0040_0040_0020_0020);
    chk("mask gt/eq", {gt_mask, eq_mask}, {8'h04, 8'h01});
    chk("mask enables", en_cnt, 2);
    finish_op("mask");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
